synth: RTL and testbench

- 12-key monophonic square-wave synthesizer with an I2S transmitter; top-level audio block between the key inputs and an external I2S DAC.
- A 12.288 MHz master clock is divided by 4 to give a 3.072 MHz i2s_bclk, which carries 64-bit stereo frames at 48 kHz.
- The highest-priority pressed key selects a note from C4 to B4. The square wave is sent as 16-bit signed samples on both channels.

---
 rtl/synth_pkg.sv | 34 +++
 rtl/synth_i2s_tx.sv | 72 +++++++
 rtl/synth.sv | 112 +++++++++++
 tb/tb_synth.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared constants for the 12-key square-wave synthesizer: I2S slot sizes,
// default amplitude, note half-period table and the key priority encoder.
package synth_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned SLOT_W   = 32;
    localparam int unsigned BC_W     = $clog2(SLOT_W);
    localparam int unsigned NUM_KEYS = 12;
    localparam int unsigned HP_W     = 8;

    localparam logic signed [SAMPLE_W-1:0] DEFAULT_AMPLITUDE = 16'sd8192;

    // Half-period in 48 kHz frames for C4..B4, index 0 = key1.
    localparam logic [HP_W-1:0] NOTE_HP [NUM_KEYS] = '{
        8'd92, 8'd87, 8'd82, 8'd77, 8'd73, 8'd69,
        8'd65, 8'd61, 8'd58, 8'd55, 8'd51, 8'd49
    };

    typedef enum logic {
        POL_POS = 1'b0,
        POL_NEG = 1'b1
    } pol_e;

    // Lowest-numbered pressed key wins; no key pressed gives 0 (silence).
    function automatic logic [HP_W-1:0] note_half_period(input logic [NUM_KEYS-1:0] keys);
        logic [HP_W-1:0] hp;
        hp = '0;
        for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
            if (keys[i]) hp = NOTE_HP[i];
        end
        return hp;
    endfunction

endpackage

// File: rtl/synth_i2s_tx.sv
// I2S transmitter: bit-clock divider, slot/bit framing, word select and an
// MSB-first sample shifter with the standard one-bclk data delay.
module synth_i2s_tx
    import synth_pkg::*;
#(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic                master_clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                frame_start_c,
    output logic                i2s_sd,
    output logic                i2s_ws,
    output logic                i2s_bclk,
    output logic [BC_W-1:0]     bit_counter
);

    localparam int unsigned DIV_W = $clog2(BCLK_DIV);
    localparam int unsigned HALF  = BCLK_DIV / 2;

    logic [DIV_W-1:0]    div_q;
    logic [DIV_W-1:0]    div_n;
    logic                fall_tick_c;
    logic                slot_end_c;
    logic                bclk_n;
    logic [SAMPLE_W-1:0] shreg_q;
    logic [SAMPLE_W-1:0] sample_q;

    // Divider wrap marks the bclk falling edge; all framing moves on it.
    always_comb begin
        fall_tick_c   = (div_q == DIV_W'(BCLK_DIV - 1));
        div_n         = fall_tick_c ? '0 : div_q + DIV_W'(1);
        bclk_n        = (div_n >= DIV_W'(HALF));
        slot_end_c    = fall_tick_c && (bit_counter == BC_W'(SLOT_W - 1));
        frame_start_c = slot_end_c && i2s_ws;
    end

    always_ff @(posedge master_clk) begin
        if (reset) begin
            div_q       <= '0;
            i2s_bclk    <= 1'b0;
            bit_counter <= '0;
            i2s_ws      <= 1'b0;
            i2s_sd      <= 1'b0;
            shreg_q     <= '0;
            sample_q    <= '0;
        end else begin
            div_q    <= div_n;
            i2s_bclk <= bclk_n;
            if (fall_tick_c) begin
                bit_counter <= bit_counter + BC_W'(1);
                if (slot_end_c) begin
                    // Slot boundary: ws flips now, the MSB follows one bclk later.
                    i2s_ws <= ~i2s_ws;
                    i2s_sd <= 1'b0;
                    if (frame_start_c) begin
                        shreg_q  <= sample;
                        sample_q <= sample;
                    end else begin
                        shreg_q  <= sample_q;
                    end
                end else if (bit_counter < BC_W'(SAMPLE_W)) begin
                    i2s_sd  <= shreg_q[SAMPLE_W-1];
                    shreg_q <= shreg_q << 1;
                end else begin
                    i2s_sd  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/synth.sv
// 12-key monophonic square-wave synthesizer driving an I2S DAC.
// Define SYNTH_KEY_SYNC_EN to add a 2-flop synchronizer on every key input.
module synth
    import synth_pkg::*;
#(
    parameter logic signed [SAMPLE_W-1:0] AMPLITUDE = DEFAULT_AMPLITUDE,
    parameter int unsigned                BCLK_DIV  = 4
) (
    input  logic              master_clk,
    input  logic              reset,
    input  logic              synth_key1,
    input  logic              synth_key2,
    input  logic              synth_key3,
    input  logic              synth_key4,
    input  logic              synth_key5,
    input  logic              synth_key6,
    input  logic              synth_key7,
    input  logic              synth_key8,
    input  logic              synth_key9,
    input  logic              synth_key10,
    input  logic              synth_key11,
    input  logic              synth_key12,
    output logic              i2s_sd,
    output logic              i2s_ws,
    output logic              i2s_bclk,
    output logic [BC_W-1:0]   bit_counter,
    output logic [HP_W-1:0]   tone_half_period
);

    logic [NUM_KEYS-1:0] keys_raw;
    logic [NUM_KEYS-1:0] keys_c;

    assign keys_raw = {synth_key12, synth_key11, synth_key10, synth_key9,
                       synth_key8,  synth_key7,  synth_key6,  synth_key5,
                       synth_key4,  synth_key3,  synth_key2,  synth_key1};

`ifdef SYNTH_KEY_SYNC_EN
    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;

    always_ff @(posedge master_clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= keys_raw;
            sync2_q <= sync1_q;
        end
    end

    assign keys_c = sync2_q;
`else
    assign keys_c = keys_raw;
`endif

    logic                frame_start_c;
    logic [HP_W-1:0]     hp_n;
    logic [HP_W-1:0]     phase_q;
    logic [HP_W-1:0]     phase_n;
    pol_e                pol_q;
    pol_e                pol_n;
    logic [SAMPLE_W-1:0] sample_c;

    // Next oscillator state for this frame; a new note restarts at phase 0, +.
    always_comb begin
        hp_n    = note_half_period(keys_c);
        phase_n = '0;
        pol_n   = POL_POS;
        if ((hp_n == tone_half_period) && (tone_half_period != '0)) begin
            if (phase_q == tone_half_period - HP_W'(1)) begin
                phase_n = '0;
                pol_n   = (pol_q == POL_POS) ? POL_NEG : POL_POS;
            end else begin
                phase_n = phase_q + HP_W'(1);
                pol_n   = pol_q;
            end
        end
        if (hp_n == '0) begin
            sample_c = '0;
        end else if (pol_n == POL_POS) begin
            sample_c = SAMPLE_W'(AMPLITUDE);
        end else begin
            sample_c = SAMPLE_W'(-AMPLITUDE);
        end
    end

    always_ff @(posedge master_clk) begin
        if (reset) begin
            tone_half_period <= '0;
            phase_q          <= '0;
            pol_q            <= POL_POS;
        end else if (frame_start_c) begin
            tone_half_period <= hp_n;
            phase_q          <= phase_n;
            pol_q            <= pol_n;
        end
    end

    synth_i2s_tx #(
        .BCLK_DIV (BCLK_DIV)
    ) u_i2s_tx (
        .master_clk    (master_clk),
        .reset         (reset),
        .sample        (sample_c),
        .frame_start_c (frame_start_c),
        .i2s_sd        (i2s_sd),
        .i2s_ws        (i2s_ws),
        .i2s_bclk      (i2s_bclk),
        .bit_counter   (bit_counter)
    );

endmodule

// File: tb/tb_synth.sv
// Directed self-checking bench for synth: reset, idle framing, tones,
// note change, key priority and mid-slot reset.
module tb_synth;

    logic        master_clk;
    logic        reset;
    logic [11:0] keys;
    logic        i2s_sd;
    logic        i2s_ws;
    logic        i2s_bclk;
    logic [4:0]  bit_counter;
    logic [7:0]  tone_half_period;

    int   total;
    int   bad;
    logic stall;

    localparam logic [31:0] SLOT_POS = 32'h1000_0000;
    localparam logic [31:0] SLOT_NEG = 32'h7000_0000;

    synth dut (
        .master_clk       (master_clk),
        .reset            (reset),
        .synth_key1       (keys[0]),
        .synth_key2       (keys[1]),
        .synth_key3       (keys[2]),
        .synth_key4       (keys[3]),
        .synth_key5       (keys[4]),
        .synth_key6       (keys[5]),
        .synth_key7       (keys[6]),
        .synth_key8       (keys[7]),
        .synth_key9       (keys[8]),
        .synth_key10      (keys[9]),
        .synth_key11      (keys[10]),
        .synth_key12      (keys[11]),
        .i2s_sd           (i2s_sd),
        .i2s_ws           (i2s_ws),
        .i2s_bclk         (i2s_bclk),
        .bit_counter      (bit_counter),
        .tone_half_period (tone_half_period)
    );

    initial master_clk = 1'b0;
    always #5 master_clk = ~master_clk;

    task automatic tick();
        @(posedge master_clk);
        #1;
    endtask

    // Advance to just after the next bclk falling edge.
    task automatic next_bit(output int cycles);
        logic prev;
        logic done;
        cycles = 0;
        done   = 1'b0;
        while (!done && cycles < 16) begin
            prev = i2s_bclk;
            tick();
            cycles++;
            if (prev && !i2s_bclk) done = 1'b1;
        end
        if (!done) stall = 1'b1;
    endtask

    // Collect one 32-bit slot; bit at bit_counter=k lands in data[31-k].
    task automatic capture_slot(output logic [31:0] data, output logic ws_v, output logic [7:0] hp_v);
        int cyc;
        int n;
        n = 0;
        data = '0;
        do begin
            next_bit(cyc);
            n++;
        end while (bit_counter != 5'd0 && n < 70);
        if (bit_counter != 5'd0) stall = 1'b1;
        data[31] = i2s_sd;
        ws_v     = i2s_ws;
        hp_v     = tone_half_period;
        for (int k = 1; k < 32; k++) begin
            next_bit(cyc);
            data[31-k] = i2s_sd;
        end
    endtask

    task automatic capture_left(output logic [31:0] data, output logic [7:0] hp_v);
        logic ws_v;
        int   n;
        n = 0;
        do begin
            capture_slot(data, ws_v, hp_v);
            n++;
        end while (ws_v != 1'b0 && n < 3);
        if (ws_v != 1'b0) stall = 1'b1;
    endtask

    task automatic test_reset();
        logic exp_bclk;
        reset = 1'b1;
        keys  = '0;
        repeat (4) tick();
        total++; if (i2s_bclk !== 1'b0) begin bad++; $display("FAIL reset_bclk got=%b want=0", i2s_bclk); end
        total++; if (i2s_ws !== 1'b0) begin bad++; $display("FAIL reset_ws got=%b want=0", i2s_ws); end
        total++; if (i2s_sd !== 1'b0) begin bad++; $display("FAIL reset_sd got=%b want=0", i2s_sd); end
        total++; if (bit_counter !== 5'd0) begin bad++; $display("FAIL reset_bc got=%0d want=0", bit_counter); end
        total++; if (tone_half_period !== 8'd0) begin bad++; $display("FAIL reset_hp got=%0d want=0", tone_half_period); end
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_bclk = ((k % 4) >= 2);
            total++;
            if (i2s_bclk !== exp_bclk) begin
                bad++; $display("FAIL bclk_wave cycle=%0d got=%b want=%b", k, i2s_bclk, exp_bclk);
            end
        end
        total++; if (bit_counter !== 5'd2) begin bad++; $display("FAIL bclk_bc got=%0d want=2", bit_counter); end
        total++; if (i2s_ws !== 1'b0) begin bad++; $display("FAIL bclk_ws got=%b want=0", i2s_ws); end
    endtask

    task automatic test_idle();
        logic [4:0] exp_bc;
        logic       exp_ws;
        int         cyc;
        exp_bc = 5'd3;
        exp_ws = 1'b0;
        for (int i = 0; i < 128; i++) begin
            next_bit(cyc);
            total++; if (bit_counter !== exp_bc) begin bad++; $display("FAIL idle_bc i=%0d got=%0d want=%0d", i, bit_counter, exp_bc); end
            total++; if (i2s_ws !== exp_ws) begin bad++; $display("FAIL idle_ws i=%0d got=%b want=%b", i, i2s_ws, exp_ws); end
            total++; if (i2s_sd !== 1'b0) begin bad++; $display("FAIL idle_sd i=%0d got=%b want=0", i, i2s_sd); end
            total++; if (tone_half_period !== 8'd0) begin bad++; $display("FAIL idle_hp i=%0d got=%0d want=0", i, tone_half_period); end
            exp_bc = exp_bc + 5'd1;
            if (exp_bc == 5'd0) exp_ws = ~exp_ws;
        end
        total++; if (stall) begin bad++; $display("FAIL idle_timeout got=stall want=progress"); stall = 1'b0; end
    endtask

    task automatic test_key1_tone();
        logic [31:0] d;
        logic [31:0] exp_d;
        logic [7:0]  hp;
        logic        ws_v;
        keys = 12'h001;
        for (int f = 0; f < 94; f++) begin
            capture_left(d, hp);
            exp_d = (f < 92) ? SLOT_POS : SLOT_NEG;
            total++; if (d !== exp_d) begin bad++; $display("FAIL key1_slot frame=%0d got=%h want=%h", f, d, exp_d); end
            if (f == 0 || f == 91 || f == 92) begin
                total++; if (hp !== 8'd92) begin bad++; $display("FAIL key1_hp frame=%0d got=%0d want=92", f, hp); end
            end
            if (f == 0) begin
                capture_slot(d, ws_v, hp);
                total++; if (ws_v !== 1'b1) begin bad++; $display("FAIL key1_right_ws got=%b want=1", ws_v); end
                total++; if (d !== SLOT_POS) begin bad++; $display("FAIL key1_right_slot got=%h want=%h", d, SLOT_POS); end
            end
        end
        total++; if (stall) begin bad++; $display("FAIL key1_timeout got=stall want=progress"); stall = 1'b0; end
    endtask

    task automatic test_note_change();
        logic [31:0] d;
        logic [7:0]  hp;
        keys = 12'h020;
        for (int f = 0; f < 70; f++) begin
            capture_left(d, hp);
            if (f == 0) begin
                total++; if (hp !== 8'd69) begin bad++; $display("FAIL change_hp got=%0d want=69", hp); end
                total++; if (d !== SLOT_POS) begin bad++; $display("FAIL change_first got=%h want=%h", d, SLOT_POS); end
            end
            if (f == 68) begin
                total++; if (d !== SLOT_POS) begin bad++; $display("FAIL change_f68 got=%h want=%h", d, SLOT_POS); end
            end
            if (f == 69) begin
                total++; if (d !== SLOT_NEG) begin bad++; $display("FAIL change_flip got=%h want=%h", d, SLOT_NEG); end
            end
        end
        total++; if (stall) begin bad++; $display("FAIL change_timeout got=stall want=progress"); stall = 1'b0; end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        logic [7:0]  hp;
        keys = 12'h801;
        capture_left(d, hp);
        total++; if (hp !== 8'd92) begin bad++; $display("FAIL prio_both_hp got=%0d want=92", hp); end
        total++; if (d !== SLOT_POS) begin bad++; $display("FAIL prio_both_slot got=%h want=%h", d, SLOT_POS); end
        keys = 12'h800;
        capture_left(d, hp);
        total++; if (hp !== 8'd49) begin bad++; $display("FAIL prio_key12_hp got=%0d want=49", hp); end
        total++; if (d !== SLOT_POS) begin bad++; $display("FAIL prio_key12_slot got=%h want=%h", d, SLOT_POS); end
        keys = 12'h000;
        capture_left(d, hp);
        total++; if (hp !== 8'd0) begin bad++; $display("FAIL silence_hp got=%0d want=0", hp); end
        total++; if (d !== 32'h0) begin bad++; $display("FAIL silence_slot got=%h want=0", d); end
        total++; if (stall) begin bad++; $display("FAIL prio_timeout got=stall want=progress"); stall = 1'b0; end
    endtask

    task automatic test_reset_mid_slot();
        logic [31:0] d;
        logic [7:0]  hp;
        logic        ws_v;
        int          cyc;
        int          n;
        keys = 12'h001;
        capture_left(d, hp);
        total++; if (hp !== 8'd92) begin bad++; $display("FAIL mid_pre_hp got=%0d want=92", hp); end
        n = 0;
        do begin
            next_bit(cyc);
            n++;
        end while (bit_counter != 5'd3 && n < 64);
        tick();
        tick();
        // Now in right slot, bit 13 of 0x2000 on sd, bclk high.
        total++; if (i2s_sd !== 1'b1) begin bad++; $display("FAIL mid_pre_sd got=%b want=1", i2s_sd); end
        total++; if (i2s_bclk !== 1'b1) begin bad++; $display("FAIL mid_pre_bclk got=%b want=1", i2s_bclk); end
        reset = 1'b1;
        tick();
        total++; if (i2s_bclk !== 1'b0) begin bad++; $display("FAIL mid_bclk got=%b want=0", i2s_bclk); end
        total++; if (i2s_ws !== 1'b0) begin bad++; $display("FAIL mid_ws got=%b want=0", i2s_ws); end
        total++; if (i2s_sd !== 1'b0) begin bad++; $display("FAIL mid_sd got=%b want=0", i2s_sd); end
        total++; if (bit_counter !== 5'd0) begin bad++; $display("FAIL mid_bc got=%0d want=0", bit_counter); end
        total++; if (tone_half_period !== 8'd0) begin bad++; $display("FAIL mid_hp got=%0d want=0", tone_half_period); end
        tick();
        tick();
        reset = 1'b0;
        next_bit(cyc);
        total++; if (cyc !== 4) begin bad++; $display("FAIL restart_fall_cycles got=%0d want=4", cyc); end
        total++; if (bit_counter !== 5'd1) begin bad++; $display("FAIL restart_bc got=%0d want=1", bit_counter); end
        total++; if (i2s_ws !== 1'b0) begin bad++; $display("FAIL restart_ws got=%b want=0", i2s_ws); end
        capture_slot(d, ws_v, hp);
        total++; if (ws_v !== 1'b1) begin bad++; $display("FAIL restart_right_ws got=%b want=1", ws_v); end
        total++; if (d !== 32'h0) begin bad++; $display("FAIL restart_right_slot got=%h want=0", d); end
        total++; if (hp !== 8'd0) begin bad++; $display("FAIL restart_right_hp got=%0d want=0", hp); end
        capture_slot(d, ws_v, hp);
        total++; if (ws_v !== 1'b0) begin bad++; $display("FAIL restart_left_ws got=%b want=0", ws_v); end
        total++; if (hp !== 8'd92) begin bad++; $display("FAIL restart_left_hp got=%0d want=92", hp); end
        total++; if (d !== SLOT_POS) begin bad++; $display("FAIL restart_left_slot got=%h want=%h", d, SLOT_POS); end
        total++; if (stall) begin bad++; $display("FAIL mid_timeout got=stall want=progress"); stall = 1'b0; end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        stall = 1'b0;
        reset = 1'b1;
        keys  = '0;
        test_reset();
        test_idle();
        test_key1_tone();
        test_note_change();
        test_priority();
        test_reset_mid_slot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
